// File: rtl/drv_segment_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
package drv_segment_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // 10^n at 32 bits; large enough for the widest supported display (8 digits).
    function automatic logic [31:0] pow10(input int unsigned n);
        logic [31:0] r;
        r = 32'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/drv_segment_dec.sv
// BCD nibble to active-low 7-segment pattern (bit 0 top, clockwise, bit 6 middle).
module drv_segment_dec
    import drv_segment_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_sgmnt
);

    always_comb begin
        o_sgmnt = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_sgmnt = 7'b1000000;
            4'd1:    o_sgmnt = 7'b1111001;
            4'd2:    o_sgmnt = 7'b0100100;
            4'd3:    o_sgmnt = 7'b0110000;
            4'd4:    o_sgmnt = 7'b0011001;
            4'd5:    o_sgmnt = 7'b0010010;
            4'd6:    o_sgmnt = 7'b0000010;
            4'd7:    o_sgmnt = 7'b1111000;
            4'd8:    o_sgmnt = 7'b0000000;
            4'd9:    o_sgmnt = 7'b0010000;
            default: o_sgmnt = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/drv_segment_mux.sv
// Binary-to-BCD (double dabble, one bit per clock) feeding a time-multiplexed
// common-anode display scanner with leading-zero blanking and overflow dash.
module drv_segment_mux
    import drv_segment_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int VALUE_W     = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [VALUE_W-1:0] i_value,
    input  logic               i_load,
    input  logic               i_blank_lz,
    output logic               o_busy,
    output logic               o_ovf,
    output logic [DIGITS-1:0]  o_drv_an,
    output logic [6:0]         o_drv_sgmnt
);

    localparam int NIB_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [31:0] OVF_LIMIT = pow10(DIGITS);

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("drv_segment_mux: DIGITS must be 1..8");
    end
    if (VALUE_W < 1 || VALUE_W > 27) begin : g_bad_value_w
        $error("drv_segment_mux: VALUE_W must be 1..27");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh
        $error("drv_segment_mux: REFRESH_DIV must be >= 2");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VALUE_W-1:0] bin_q, bin_d;
    logic [NIB_W-1:0]   bcd_q, bcd_d;
    logic [NIB_W-1:0]   bcd_shift;
    logic               ovf_pend_q, ovf_pend_d;
    logic [NIB_W-1:0]   disp_q, disp_d;
    logic               ovf_q, ovf_d;

    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DIGITS-1:0]  an_q, an_d;
    logic [6:0]         sgmnt_q, sgmnt_d;
    logic [DIGITS-1:0]  lz;
    logic [3:0]         nib_sel;
    logic [6:0]         dec_seg;

    function automatic logic [NIB_W-1:0] add3(input logic [NIB_W-1:0] v);
        logic [NIB_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Conversion FSM: one add-3/shift step per cycle while in CONV.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        ovf_pend_d = ovf_pend_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        bcd_shift  = {add3(bcd_q), bin_q[VALUE_W-1]} >> 0;
        case (state_q)
            IDLE: begin
                if (i_load) begin
                    bin_d      = i_value;
                    bcd_d      = '0;
                    cnt_d      = CNT_W'(VALUE_W);
                    ovf_pend_d = (32'(i_value) >= OVF_LIMIT);
                    state_d    = CONV;
                end
            end
            CONV: begin
                bin_d = bin_q << 1;
                bcd_d = bcd_shift;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    disp_d  = bcd_shift;
                    ovf_d   = ovf_pend_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scanner: prescaled digit rotation and the registered segment/anode drive.
    always_comb begin
        presc_d = presc_q + PRE_W'(1);
        idx_d   = idx_q;
        if (presc_q == PRE_W'(REFRESH_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        for (int d = 0; d < DIGITS; d++) begin
            lz[d] = 1'b1;
            for (int k = d; k < DIGITS; k++) begin
                if (disp_q[4*k +: 4] != 4'd0) begin
                    lz[d] = 1'b0;
                end
            end
        end

        nib_sel = disp_q[4*idx_q +: 4];
        an_d    = ~(DIGITS'(1) << idx_q);
        if (ovf_q) begin
            sgmnt_d = SEG_DASH;
        end else if (i_blank_lz && (idx_q != '0) && lz[idx_q]) begin
            sgmnt_d = SEG_BLANK;
        end else begin
            sgmnt_d = dec_seg;
        end
    end

    drv_segment_dec u_dec (
        .i_bcd   (nib_sel),
        .o_sgmnt (dec_seg)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= ~(DIGITS'(1));
            sgmnt_q <= SEG_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            sgmnt_q <= sgmnt_d;
        end
    end

    // Conversion scratch is only meaningful while in CONV, so it carries no reset.
    always_ff @(posedge i_clk) begin
        bin_q      <= bin_d;
        bcd_q      <= bcd_d;
        ovf_pend_q <= ovf_pend_d;
    end

    assign o_busy      = (state_q == CONV);
    assign o_ovf       = ovf_q;
    assign o_drv_an    = an_q;
    assign o_drv_sgmnt = sgmnt_q;

endmodule

// File: tb/tb_drv_segment_mux.sv
// Directed bench for drv_segment_mux; expected digit patterns come from an
// arithmetic decimal model and are queued at load time, popped per scan slot.
module tb_drv_segment_mux;

    localparam int DIGITS      = 4;
    localparam int VALUE_W     = 14;
    localparam int REFRESH_DIV = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [VALUE_W-1:0] value;
    logic               load;
    logic               blank;
    logic               busy;
    logic               ovf;
    logic [DIGITS-1:0]  an;
    logic [6:0]         sgmnt;

    int         checks = 0;
    int         errors = 0;
    logic [6:0] sb[$];
    logic       exp_ovf = 1'b0;
    int         last_value = 0;

    always #5 clk = ~clk;

    drv_segment_mux #(
        .DIGITS      (DIGITS),
        .VALUE_W     (VALUE_W),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_value     (value),
        .i_load      (load),
        .i_blank_lz  (blank),
        .o_busy      (busy),
        .o_ovf       (ovf),
        .o_drv_an    (an),
        .o_drv_sgmnt (sgmnt)
    );

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] digit_seg(int n);
        case (n)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int p10(int d);
        int r = 1;
        for (int i = 0; i < d; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] model_seg(int v, int d, logic bl);
        if (v >= p10(DIGITS)) return 7'b0111111;
        if (bl && d != 0 && v < p10(d)) return 7'b1111111;
        return digit_seg((v / p10(d)) % 10);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expect(int v);
        for (int d = 0; d < DIGITS; d++) sb.push_back(model_seg(v, d, blank));
        exp_ovf    = (v >= p10(DIGITS));
        last_value = v;
    endtask

    task automatic check_display(string tag);
        logic [DIGITS-1:0] want_an;
        logic [6:0]        want_seg;
        int                w;
        check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
        for (int d = 0; d < DIGITS; d++) begin
            want_an = ~(DIGITS'(1) << d);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (an !== want_an && w < 40);
            check($sformatf("%s an%0d", tag, d), 32'(an), 32'(want_an));
            if (sb.size() == 0) begin
                check($sformatf("%s scoreboard empty d%0d", tag, d), 32'd0, 32'd1);
            end else begin
                want_seg = sb.pop_front();
                check($sformatf("%s seg%0d", tag, d), 32'(sgmnt), 32'(want_seg));
            end
        end
    endtask

    task automatic do_load(int v, int pulse_at, output int busy_cycles);
        int n;
        @(negedge clk);
        value = VALUE_W'(v);
        load  = 1'b1;
        push_expect(v);
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == pulse_at) begin
                load  = 1'b1;
                value = VALUE_W'(42);
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        busy_cycles = n;
    endtask

    initial begin
        int                n;
        logic [DIGITS-1:0] rot;
        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        blank = 1'b0;

        repeat (3) @(negedge clk);
        check("reset an", 32'(an), 32'(4'b1110));
        check("reset seg", 32'(sgmnt), 32'(7'b1000000));
        check("reset busy", 32'(busy), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);

        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            rot = ~(DIGITS'(1) << (((k - 1) / REFRESH_DIV) % DIGITS));
            check($sformatf("rotate k%0d", k), 32'(an), 32'(rot));
        end
        check("rotate seg", 32'(sgmnt), 32'(7'b1000000));

        do_load(1234, 0, n);
        check("1234 busy cycles", 32'(n), 32'(VALUE_W));
        check_display("1234");

        blank = 1'b1;
        do_load(7, 0, n);
        check("7 busy cycles", 32'(n), 32'(VALUE_W));
        check_display("7 blank");
        blank = 1'b0;
        push_expect(last_value);
        check_display("7 noblank");

        do_load(12000, 0, n);
        check_display("12000");
        do_load(9999, 0, n);
        check_display("9999");
        do_load(10000, 0, n);
        check_display("10000");

        do_load(5555, 5, n);
        check("5555 busy cycles", 32'(n), 32'(VALUE_W));
        check_display("5555");

        blank = 1'b1;
        do_load(0, 0, n);
        check_display("0 blank");
        blank = 1'b0;

        @(negedge clk);
        value = VALUE_W'(8888);
        load  = 1'b1;
        push_expect(0);
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        check("8888 busy before reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("8888 busy after reset", 32'(busy), 32'd0);
        check("8888 an after reset", 32'(an), 32'(4'b1110));
        check_display("8888 reset");
        repeat (VALUE_W + 2) @(negedge clk);
        check("8888 no late update busy", 32'(busy), 32'd0);
        check("8888 no late update ovf", 32'(ovf), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
